// File: rtl/decode_stage.sv
// Decode stage: register-file read with write-through bypass, control decode,
// early beq/j resolution with fetch redirect and wrong-path squash.
module decode_stage #(
  parameter int SQUASH_SLOTS = 1,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ir_i,
  input  logic [31:0]       npc_i,
  input  logic              id_en,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pc_update,
  output logic [31:0]       pc_i,
  output logic              ex_valid,
  output logic [2:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_dst,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_alusrc,
  output logic              illegal
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [2:0] SLOTS = 3'(SQUASH_SLOTS);

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic [DATA_W-1:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [25:0] tgt;
  logic [31:0] imm_sext;

  assign op       = ir_i[31:26];
  assign rs       = ir_i[25:21];
  assign rt       = ir_i[20:16];
  assign rd       = ir_i[15:11];
  assign funct    = ir_i[5:0];
  assign tgt      = ir_i[25:0];
  assign imm_sext = {{16{ir_i[15]}}, ir_i[15:0]};

  logic [DATA_W-1:0] rs_val, rt_val;

  // Writeback data is forwarded to a same-cycle read; r0 is hardwired to zero.
  always_comb begin
    rs_val = rf[rs];
    rt_val = rf[rt];
    if (wb_we && wb_addr == rs) rs_val = wb_data;
    if (wb_we && wb_addr == rt) rt_val = wb_data;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  logic [2:0] d_aluop;
  logic [4:0] d_dst;
  logic       d_rw, d_mr, d_mw, d_src;
  logic       dec_ok, dec_bad, is_beq, is_j;

  always_comb begin
    d_aluop = 3'd0;
    d_dst   = 5'd0;
    d_rw    = 1'b0;
    d_mr    = 1'b0;
    d_mw    = 1'b0;
    d_src   = 1'b0;
    dec_ok  = 1'b0;
    dec_bad = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin dec_ok = 1'b1; d_aluop = 3'd0; d_dst = rd; d_rw = 1'b1; end
          6'h22: begin dec_ok = 1'b1; d_aluop = 3'd1; d_dst = rd; d_rw = 1'b1; end
          6'h24: begin dec_ok = 1'b1; d_aluop = 3'd2; d_dst = rd; d_rw = 1'b1; end
          6'h25: begin dec_ok = 1'b1; d_aluop = 3'd3; d_dst = rd; d_rw = 1'b1; end
          6'h2A: begin dec_ok = 1'b1; d_aluop = 3'd4; d_dst = rd; d_rw = 1'b1; end
          6'h00: begin dec_ok = 1'b1; d_dst = rd; end
          default: dec_bad = 1'b1;
        endcase
      end
      6'h08: begin dec_ok = 1'b1; d_dst = rt; d_src = 1'b1; d_rw = 1'b1; end
      6'h23: begin dec_ok = 1'b1; d_dst = rt; d_src = 1'b1; d_rw = 1'b1; d_mr = 1'b1; end
      6'h2B: begin dec_ok = 1'b1; d_src = 1'b1; d_mw = 1'b1; end
      6'h04: is_beq = 1'b1;
      6'h02: is_j = 1'b1;
      default: dec_bad = 1'b1;
    endcase
  end

  logic        active, redirect;
  logic [31:0] target;

  assign active   = id_en && (state == RUN);
  assign redirect = active && (is_j || (is_beq && rs_val == rt_val));
  assign target   = is_j ? {npc_i[31:26], tgt} : npc_i + imm_sext;

  // Squash counts only cycles that actually carry a fetched instruction.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (redirect && SLOTS != 3'd0) begin
          state_nxt = SQUASH;
          cnt_nxt   = SLOTS;
        end
      end
      SQUASH: begin
        if (cnt == 3'd0) begin
          state_nxt = RUN;
        end else if (id_en) begin
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_update   <= 1'b0;
      pc_i        <= '0;
      ex_valid    <= 1'b0;
      illegal     <= 1'b0;
      ex_aluop    <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_dst      <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
    end else begin
      pc_update <= redirect;
      ex_valid  <= active && dec_ok;
      illegal   <= active && dec_bad;
      if (redirect) pc_i <= target;
      // Bubbles, squashed slots and control/illegal ops leave the bundle fields untouched.
      if (active && dec_ok) begin
        ex_aluop    <= d_aluop;
        ex_a        <= rs_val;
        ex_b        <= rt_val;
        ex_imm      <= imm_sext;
        ex_dst      <= d_dst;
        ex_regwrite <= d_rw;
        ex_memread  <= d_mr;
        ex_memwrite <= d_mw;
        ex_alusrc   <= d_src;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage: dut_a uses one squash slot, dut_b two;
// both see identical stimulus and dut_b is checked on its valid/redirect view.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir, npc;
  logic        id_en, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        a_pcu, a_valid, a_rw, a_mr, a_mw, a_src, a_ill;
  logic [31:0] a_pci, a_a, a_b, a_imm;
  logic [2:0]  a_aluop;
  logic [4:0]  a_dst;
  logic        b_pcu, b_valid, b_rw, b_mr, b_mw, b_src, b_ill;
  logic [31:0] b_pci, b_a, b_b, b_imm;
  logic [2:0]  b_aluop;
  logic [4:0]  b_dst;

  always #5 clk = ~clk;

  decode_stage #(.SQUASH_SLOTS(1), .DATA_W(32)) dut_a (
    .clk(clk), .rst(rst), .ir_i(ir), .npc_i(npc), .id_en(id_en),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_update(a_pcu), .pc_i(a_pci), .ex_valid(a_valid), .ex_aluop(a_aluop),
    .ex_a(a_a), .ex_b(a_b), .ex_imm(a_imm), .ex_dst(a_dst),
    .ex_regwrite(a_rw), .ex_memread(a_mr), .ex_memwrite(a_mw),
    .ex_alusrc(a_src), .illegal(a_ill)
  );

  decode_stage #(.SQUASH_SLOTS(2), .DATA_W(32)) dut_b (
    .clk(clk), .rst(rst), .ir_i(ir), .npc_i(npc), .id_en(id_en),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_update(b_pcu), .pc_i(b_pci), .ex_valid(b_valid), .ex_aluop(b_aluop),
    .ex_a(b_a), .ex_b(b_b), .ex_imm(b_imm), .ex_dst(b_dst),
    .ex_regwrite(b_rw), .ex_memread(b_mr), .ex_memwrite(b_mw),
    .ex_alusrc(b_src), .illegal(b_ill)
  );

  typedef struct {
    logic [2:0]  aluop;
    logic [31:0] a, b, imm;
    logic [4:0]  dst;
    logic        rw, mr, mw, src;
  } fld_t;

  typedef struct {
    logic        en;
    logic [31:0] ir, npc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        v, pu;
    logic [31:0] pci;
    logic        ill;
    fld_t        f;
    logic        vb, pub;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic fld_t fld(input logic [2:0] aluop, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm,
                               input logic [4:0] dst, input logic rw, input logic mr,
                               input logic mw, input logic src);
    fld_t r;
    r.aluop = aluop; r.a = a; r.b = b; r.imm = imm; r.dst = dst;
    r.rw = rw; r.mr = mr; r.mw = mw; r.src = src;
    return r;
  endfunction

  function automatic vec_t vec(input logic en, input logic [31:0] vir, input logic [31:0] vnpc,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic v, input logic pu, input logic [31:0] pci,
                               input logic ill, input fld_t f, input logic vb, input logic pub);
    vec_t r;
    r.en = en; r.ir = vir; r.npc = vnpc; r.we = we; r.wa = wa; r.wd = wd;
    r.v = v; r.pu = pu; r.pci = pci; r.ill = ill; r.f = f; r.vb = vb; r.pub = pub;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      cmp("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      cmp("ex_valid", a_valid, e.v);
      cmp("pc_update", a_pcu, e.pu);
      cmp("pc_i", a_pci, e.pci);
      cmp("illegal", a_ill, e.ill);
      cmp("ex_aluop", a_aluop, e.f.aluop);
      cmp("ex_a", a_a, e.f.a);
      cmp("ex_b", a_b, e.f.b);
      cmp("ex_imm", a_imm, e.f.imm);
      cmp("ex_dst", a_dst, e.f.dst);
      cmp("ex_regwrite", a_rw, e.f.rw);
      cmp("ex_memread", a_mr, e.f.mr);
      cmp("ex_memwrite", a_mw, e.f.mw);
      cmp("ex_alusrc", a_src, e.f.src);
      cmp("b_ex_valid", b_valid, e.vb);
      cmp("b_pc_update", b_pcu, e.pub);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    id_en   = t.en;
    ir      = t.ir;
    npc     = t.npc;
    wb_we   = t.we;
    wb_addr = t.wa;
    wb_data = t.wd;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, "_a_outputs"}, {a_pcu, a_valid, a_rw, a_mr, a_mw, a_src, a_ill, a_aluop, a_dst}, 32'd0);
    cmp({tag, "_a_pc_i"}, a_pci, 32'd0);
    cmp({tag, "_a_ex_a"}, a_a, 32'd0);
    cmp({tag, "_a_ex_b"}, a_b, 32'd0);
    cmp({tag, "_a_ex_imm"}, a_imm, 32'd0);
    cmp({tag, "_b_outputs"}, {b_pcu, b_valid, b_rw, b_mr, b_mw, b_src, b_ill, b_aluop, b_dst}, 32'd0);
    cmp({tag, "_b_data"}, b_pci | b_a | b_b | b_imm, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fld_t F0, FADD59, FADDI, FADD55, FADD56, FR0, FLW, FSW, FSUB, FAND, FOR, FSLT, FCLR;
    F0     = fld(3'd0, 32'd0, 32'd0, 32'd0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    FADD59 = fld(3'd0, 32'd5, 32'd9, 32'h1820,     5'd3,  1'b1, 1'b0, 1'b0, 1'b0);
    FADDI  = fld(3'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1);
    FADD55 = fld(3'd0, 32'd5, 32'd5, 32'h1820,     5'd3,  1'b1, 1'b0, 1'b0, 1'b0);
    FADD56 = fld(3'd0, 32'd5, 32'd6, 32'h1820,     5'd3,  1'b1, 1'b0, 1'b0, 1'b0);
    FR0    = fld(3'd0, 32'd0, 32'd0, 32'h2820,     5'd5,  1'b1, 1'b0, 1'b0, 1'b0);
    FLW    = fld(3'd0, 32'd5, 32'd0, 32'h4,        5'd6,  1'b1, 1'b1, 1'b0, 1'b1);
    FSW    = fld(3'd0, 32'd5, 32'd6, 32'hFFFFFFF8, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1);
    FSUB   = fld(3'd1, 32'd5, 32'd6, 32'h3822,     5'd7,  1'b1, 1'b0, 1'b0, 1'b0);
    FAND   = fld(3'd2, 32'd5, 32'd6, 32'h4024,     5'd8,  1'b1, 1'b0, 1'b0, 1'b0);
    FOR    = fld(3'd3, 32'd5, 32'd6, 32'h4825,     5'd9,  1'b1, 1'b0, 1'b0, 1'b0);
    FSLT   = fld(3'd4, 32'd5, 32'd6, 32'h502A,     5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    FCLR   = fld(3'd0, 32'd0, 32'd0, 32'h1820,     5'd3,  1'b1, 1'b0, 1'b0, 1'b0);

    //          en ir            npc           we wa  wd        v  pu pci           ill f       vb pub
    tbl.push_back(vec(1, 32'h00000000, 32'h1,        0, 0, 32'h0,     1, 0, 32'h0,        0, F0,     1, 0));
    tbl.push_back(vec(0, 32'h00000000, 32'h0,        1, 1, 32'd5,     0, 0, 32'h0,        0, F0,     0, 0));
    tbl.push_back(vec(0, 32'h00000000, 32'h0,        1, 2, 32'd7,     0, 0, 32'h0,        0, F0,     0, 0));
    tbl.push_back(vec(1, 32'h00221820, 32'h2,        1, 2, 32'd9,     1, 0, 32'h0,        0, FADD59, 1, 0));
    tbl.push_back(vec(1, 32'h2004FFFF, 32'h3,        1, 2, 32'd5,     1, 0, 32'h0,        0, FADDI,  1, 0));
    tbl.push_back(vec(1, 32'h10220003, 32'h8,        0, 0, 32'h0,     0, 1, 32'h0B,       0, FADDI,  0, 1));
    tbl.push_back(vec(1, 32'h00221820, 32'h9,        0, 0, 32'h0,     0, 0, 32'h0B,       0, FADDI,  0, 0));
    tbl.push_back(vec(1, 32'h00221820, 32'hC,        0, 0, 32'h0,     1, 0, 32'h0B,       0, FADD55, 0, 0));
    tbl.push_back(vec(1, 32'h10220003, 32'h8,        1, 2, 32'd6,     0, 0, 32'h0B,       0, FADD55, 0, 0));
    tbl.push_back(vec(1, 32'h08000040, 32'h10,       0, 0, 32'h0,     0, 1, 32'h40,       0, FADD55, 0, 1));
    tbl.push_back(vec(1, 32'h00221820, 32'h41,       0, 0, 32'h0,     0, 0, 32'h40,       0, FADD55, 0, 0));
    tbl.push_back(vec(0, 32'h00221820, 32'h42,       0, 0, 32'h0,     0, 0, 32'h40,       0, FADD55, 0, 0));
    tbl.push_back(vec(1, 32'h00221820, 32'h42,       0, 0, 32'h0,     1, 0, 32'h40,       0, FADD56, 0, 0));
    tbl.push_back(vec(1, 32'h00221820, 32'h43,       0, 0, 32'h0,     1, 0, 32'h40,       0, FADD56, 1, 0));
    tbl.push_back(vec(1, 32'h08000040, 32'h10,       0, 0, 32'h0,     0, 1, 32'h40,       0, FADD56, 0, 1));
    tbl.push_back(vec(1, 32'h08000080, 32'h20,       0, 0, 32'h0,     0, 0, 32'h40,       0, FADD56, 0, 0));
    tbl.push_back(vec(1, 32'h00221820, 32'h21,       0, 0, 32'h0,     1, 0, 32'h40,       0, FADD56, 0, 0));
    tbl.push_back(vec(1, 32'h00221820, 32'h22,       0, 0, 32'h0,     1, 0, 32'h40,       0, FADD56, 1, 0));
    tbl.push_back(vec(1, 32'hFC000000, 32'h23,       0, 0, 32'h0,     0, 0, 32'h40,       1, FADD56, 0, 0));
    tbl.push_back(vec(0, 32'h00000000, 32'h0,        1, 0, 32'hDEAD,  0, 0, 32'h40,       0, FADD56, 0, 0));
    tbl.push_back(vec(1, 32'h00002820, 32'h24,       0, 0, 32'h0,     1, 0, 32'h40,       0, FR0,    1, 0));
    tbl.push_back(vec(1, 32'h00002820, 32'h25,       1, 0, 32'hBEEF,  1, 0, 32'h40,       0, FR0,    1, 0));
    tbl.push_back(vec(1, 32'h8C260004, 32'h26,       0, 0, 32'h0,     1, 0, 32'h40,       0, FLW,    1, 0));
    tbl.push_back(vec(1, 32'hAC22FFF8, 32'h27,       0, 0, 32'h0,     1, 0, 32'h40,       0, FSW,    1, 0));
    tbl.push_back(vec(1, 32'h00223822, 32'h28,       0, 0, 32'h0,     1, 0, 32'h40,       0, FSUB,   1, 0));
    tbl.push_back(vec(1, 32'h00224024, 32'h29,       0, 0, 32'h0,     1, 0, 32'h40,       0, FAND,   1, 0));
    tbl.push_back(vec(1, 32'h00224825, 32'h2A,       0, 0, 32'h0,     1, 0, 32'h40,       0, FOR,    1, 0));
    tbl.push_back(vec(1, 32'h0022502A, 32'h2B,       0, 0, 32'h0,     1, 0, 32'h40,       0, FSLT,   1, 0));
    tbl.push_back(vec(1, 32'h00221821, 32'h2C,       0, 0, 32'h0,     0, 0, 32'h40,       1, FSLT,   0, 0));
    tbl.push_back(vec(1, 32'h1021FFFE, 32'h100,      0, 0, 32'h0,     0, 1, 32'hFE,       0, FSLT,   0, 1));
    tbl.push_back(vec(1, 32'h00221820, 32'h101,      0, 0, 32'h0,     0, 0, 32'hFE,       0, FSLT,   0, 0));
    tbl.push_back(vec(1, 32'h00221820, 32'h102,      0, 0, 32'h0,     1, 0, 32'hFE,       0, FADD56, 0, 0));
    tbl.push_back(vec(1, 32'h1021FFFF, 32'h0,        0, 0, 32'h0,     0, 1, 32'hFFFFFFFF, 0, FADD56, 0, 1));
    tbl.push_back(vec(1, 32'h00221820, 32'h1,        0, 0, 32'h0,     0, 0, 32'hFFFFFFFF, 0, FADD56, 0, 0));
    tbl.push_back(vec(1, 32'h00221820, 32'h2,        0, 0, 32'h0,     1, 0, 32'hFFFFFFFF, 0, FADD56, 0, 0));
    tbl.push_back(vec(1, 32'h08000040, 32'hF0000010, 0, 0, 32'h0,     0, 1, 32'hF0000040, 0, FADD56, 0, 1));
    tbl.push_back(vec(1, 32'h00221820, 32'hF0000011, 0, 0, 32'h0,     0, 0, 32'hF0000040, 0, FADD56, 0, 0));
    tbl.push_back(vec(1, 32'h00221820, 32'hF0000012, 0, 0, 32'h0,     1, 0, 32'hF0000040, 0, FADD56, 0, 0));

    rst = 1'b0; id_en = 1'b0; ir = '0; npc = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst = 1'b1;

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Reset arriving while the redirect pulse is high and both DUTs are squashing.
    applyStimulus(vec(1, 32'h08000040, 32'h10, 0, 0, 32'h0, 0, 1, 32'h40, 0, FADD56, 0, 1));
    id_en = 1'b0;
    #1 rst = 1'b0;
    #1 checkReset("mid_pulse");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(vec(1, 32'h00221820, 32'h11, 0, 0, 32'h0, 1, 0, 32'h0, 0, FCLR, 1, 0));

    $display("[TB] scoreboard entries left: %0d", exp_q.size());
    cmp("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
